// File: rtl/rv32v_uop_sequencer.sv
// rv32v_uop_sequencer: splits one issued vector instruction into
// NUM_LANES-element micro-ops for the EX/MEM vector fields.
// Optional feature macro: RV32V_UOP_SKIP_EN. When it is defined, non-last
// uops with an all-zero lane mask are stepped over without being presented.

// Per-lane activity for element e = num*NUM_LANES + LANE.
module rv32v_uop_lane #(
  parameter int UW    = 5,
  parameter int LW    = 2,
  parameter int VLMAX = 128,
  parameter int LANE  = 0
) (
  input  logic [UW-1:0]              num,
  input  logic [$clog2(VLMAX):0]     vl,
  input  logic [$clog2(VLMAX)-1:0]   vstart,
  input  logic                       vm,
  input  logic [VLMAX-1:0]           v0_mask,
  output logic                       active
);
  localparam int EW = UW + LW + 1;
  localparam logic [LW-1:0] LIDX = LW'(LANE);

  // One spare top bit so the element index never wraps against vl.
  logic [EW-1:0] e;
  assign e      = {1'b0, num, LIDX};
  assign active = (e < vl) & (e >= {1'b0, vstart}) & (vm | v0_mask[e[EW-2:0]]);
endmodule

module rv32v_uop_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int VLMAX     = 128,
  parameter int UW        = $clog2(VLMAX / NUM_LANES)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [$clog2(VLMAX):0]     vl,
  input  logic [$clog2(VLMAX)-1:0]   vstart,
  input  logic                       vm,
  input  logic [VLMAX-1:0]           v0_mask,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       uop_valid,
  output logic [UW-1:0]              vuop_num,
  output logic                       vuop_last,
  output logic [NUM_LANES-1:0]       vlane_mask,
  output logic [1:0]                 vbank_offset,
  output logic                       busy
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int VW = $clog2(VLMAX) + 1;
  localparam int NW = VW - LW + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t               state;
  logic [VW-1:0]        vl_q;
  logic [VW-2:0]        vstart_q;
  logic                 vm_q;
  logic [VLMAX-1:0]     v0_q;

  logic [UW-1:0]        first_q;
  logic [NW-1:0]        n_uops;
  logic [NW-1:0]        n_m1;
  logic [UW-1:0]        last_idx;
  logic [NUM_LANES-1:0] raw_mask;
  logic                 in_issue;
  logic                 at_last;
  logic                 accept;

  assign first_q = vstart_q[VW-2:LW];
  assign n_uops  = NW'(({1'b0, vl_q} + (VW+1)'(NUM_LANES - 1)) >> LW);

  // Final uop index: last element's uop, but never before the vstart uop.
  always_comb begin
    n_m1     = n_uops - NW'(1);
    last_idx = first_q;
    if (vl_q != '0 && n_m1 > NW'(first_q)) last_idx = n_m1[UW-1:0];
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rv32v_uop_lane #(.UW(UW), .LW(LW), .VLMAX(VLMAX), .LANE(i)) u_lane (
      .num     (vuop_num),
      .vl      (vl_q),
      .vstart  (vstart_q),
      .vm      (vm_q),
      .v0_mask (v0_q),
      .active  (raw_mask[i])
    );
  end

  assign in_issue = (state == ISSUE);
  assign at_last  = in_issue & (vuop_num == last_idx);

`ifdef RV32V_UOP_SKIP_EN
  // Zero-mask uops are only shown when they are the final one.
  assign uop_valid = in_issue & (at_last | (|raw_mask));
`else
  assign uop_valid = in_issue;
`endif

  assign vuop_last    = at_last;
  assign vlane_mask   = in_issue ? raw_mask : '0;
  assign vbank_offset = vuop_num[1:0];
  assign busy         = in_issue & ~(at_last & ~stall);
  assign accept       = start & ~flush & ~busy;

  // Sequencer FSM: latch on accept, step uops, retire or chain the next instr.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      vuop_num <= '0;
      vl_q     <= '0;
      vstart_q <= '0;
      vm_q     <= 1'b0;
      v0_q     <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state    <= ISSUE;
      vl_q     <= vl;
      vstart_q <= vstart;
      vm_q     <= vm;
      v0_q     <= v0_mask;
      vuop_num <= vstart[VW-2:LW];
    end else if (in_issue) begin
      if (!uop_valid) begin
        vuop_num <= vuop_num + UW'(1);
      end else if (!stall) begin
        if (at_last) state    <= IDLE;
        else         vuop_num <= vuop_num + UW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Randomized + directed bench for rv32v_uop_sequencer against a queue-based
// model that expands each accepted instruction into its list of uops.
module tb_rv32v_uop_sequencer;
  localparam int NL    = 4;
  localparam int VLMAX = 128;
  localparam int UW    = 5;

  logic             CLK = 1'b0;
  logic             RST, start, vm, stall, flush;
  logic [7:0]       vl;
  logic [6:0]       vstart;
  logic [VLMAX-1:0] v0_mask;
  logic             uop_valid, vuop_last, busy;
  logic [UW-1:0]    vuop_num;
  logic [NL-1:0]    vlane_mask;
  logic [1:0]       vbank_offset;

  rv32v_uop_sequencer #(.NUM_LANES(NL), .VLMAX(VLMAX)) dut (
    .CLK(CLK), .RST(RST), .start(start), .vl(vl), .vstart(vstart), .vm(vm),
    .v0_mask(v0_mask), .stall(stall), .flush(flush), .uop_valid(uop_valid),
    .vuop_num(vuop_num), .vuop_last(vuop_last), .vlane_mask(vlane_mask),
    .vbank_offset(vbank_offset), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct { bit pres; int num; int mask; bit last; } uop_t;
  uop_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Element-level view of one instruction: which uops exist and their masks.
  function automatic void expand(int l, int vs, bit m, logic [VLMAX-1:0] v0);
    int first = vs / NL;
    int lst   = (l + NL - 1) / NL - 1;
    if (lst < first) lst = first;
    for (int u = first; u <= lst; u++) begin
      uop_t x;
      x.num  = u;
      x.mask = 0;
      x.last = (u == lst);
      for (int i = 0; i < NL; i++) begin
        int e = u * NL + i;
        if (e < l && e >= vs && (m || v0[e])) x.mask |= (1 << i);
      end
      x.pres = 1'b1;
`ifdef RV32V_UOP_SKIP_EN
      if (x.mask == 0 && !x.last) x.pres = 1'b0;
`endif
      q.push_back(x);
    end
  endfunction

  // One clock: apply inputs, check this cycle's outputs, advance the model.
  task automatic step(bit st, bit sl, bit fl, bit rs, int ivl, int ivs, bit ivm,
                      logic [VLMAX-1:0] iv0);
    bit   eb;
    bit   acc;
    uop_t f;
    @(negedge CLK);
    start = st; stall = sl; flush = fl; RST = rs;
    vl = 8'(ivl); vstart = 7'(ivs); vm = ivm; v0_mask = iv0;
    #1;
    if (q.size() == 0) begin
      eb = 1'b0;
      chk("uop_valid_idle", {31'b0, uop_valid}, 0);
      chk("busy_idle", {31'b0, busy}, 0);
      chk("vuop_last_idle", {31'b0, vuop_last}, 0);
      chk("vlane_mask_idle", {28'b0, vlane_mask}, 0);
    end else begin
      f  = q[0];
      eb = !(f.pres && f.last && !sl);
      chk("uop_valid", {31'b0, uop_valid}, {31'b0, f.pres});
      chk("busy", {31'b0, busy}, {31'b0, eb});
      chk("vuop_last", {31'b0, vuop_last}, {31'b0, f.pres & f.last});
      chk("vlane_mask", {28'b0, vlane_mask}, f.mask);
      if (f.pres) begin
        chk("vuop_num", {27'b0, vuop_num}, f.num);
        chk("vbank_offset", {30'b0, vbank_offset}, f.num % 4);
      end
    end
    if (rs || fl) begin
      q.delete();
    end else begin
      acc = st && !eb;
      if (q.size() > 0 && (!q[0].pres || !sl)) void'(q.pop_front());
      if (acc) expand(ivl, ivs, ivm, iv0);
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 1, '0);
  endtask

  task automatic drain(int budget);
    int k = 0;
    while (q.size() > 0 && k < budget) begin
      step(0, 0, 0, 0, 0, 0, 1, '0);
      k++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic issue(int l, int vs, bit m, logic [VLMAX-1:0] v0);
    step(1, 0, 0, 0, l, vs, m, v0);
  endtask

  initial begin
    logic [VLMAX-1:0] rv0;
    start = 0; stall = 0; flush = 0; vm = 1; vl = 0; vstart = 0; v0_mask = '0;
    RST = 1;
    step(0, 0, 0, 1, 0, 0, 1, '0);
    step(0, 0, 0, 1, 0, 0, 1, '0);
    @(posedge CLK); #1;
    chk("rst_vuop_num", {27'b0, vuop_num}, 0);
    chk("rst_vbank", {30'b0, vbank_offset}, 0);
    chk("rst_uop_valid", {31'b0, uop_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    idle(1);

    // 1: three full/partial uops.
    issue(10, 0, 1, '0);  drain(20);
    // 2: vstart skips uop 0.
    issue(10, 6, 1, '0);  drain(20);
    // 3: v0-masked, second uop empty but last.
    issue(8, 0, 0, 128'h5); drain(20);
    // 4: stall three cycles on uop1.
    issue(16, 0, 1, '0);
    step(0, 0, 0, 0, 0, 0, 1, '0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 1, '0);
    drain(20);
    // 5: flush with start during uop1, then a clean restart.
    issue(16, 0, 1, '0);
    step(0, 0, 0, 0, 0, 0, 1, '0);
    step(1, 0, 1, 0, 8, 0, 1, '0);
    idle(1);
    issue(8, 0, 1, '0);   drain(20);
    // 6: vl=0 single uop, chained back-to-back starts.
    issue(0, 0, 1, '0);
    issue(0, 0, 1, '0);
    issue(12, 0, 1, '0);  drain(20);
    // 7: v0 bits 0-11 clear.
    issue(16, 0, 0, 128'hA000); drain(20);
    // vstart >= vl, and a start while busy that must be ignored.
    issue(5, 40, 1, '0);  drain(20);
    issue(12, 0, 1, '0);
    step(1, 0, 0, 0, 4, 0, 1, '0);
    drain(20);
    // Reset mid-sequence.
    issue(32, 0, 1, '0);
    step(0, 0, 0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 1, 0, 0, 1, '0);
    idle(3);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      int rl, rvs;
      rv0 = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(3) == 0) rv0 = rv0 & {$urandom, $urandom, $urandom, $urandom};
      rl  = $urandom_range(VLMAX);
      rvs = ($urandom_range(3) == 0) ? $urandom_range(VLMAX - 1) : $urandom_range(7);
      step($urandom_range(99) < 40, $urandom_range(99) < 25, $urandom_range(99) < 3,
           $urandom_range(199) < 1, rl, rvs, $urandom_range(1) == 1, rv0);
    end
    drain(200);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
